wb_arbiter2: RTL and testbench



---
 rtl/wb_arbiter2_pkg.sv | 14 +
 rtl/wb_watchdog.sv | 40 ++++
 rtl/wb_arbiter2.sv | 124 ++++++++++++
 tb/tb_wb_arbiter2.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter2_pkg.sv
// Shared Wishbone widths, arbiter state encoding and the default watchdog read data.
package wb_arbiter2_pkg;
  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  localparam logic [WB_DAT_W-1:0] WB_TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;
endpackage

// File: rtl/wb_watchdog.sv
// Bus-timeout watchdog: counts unacknowledged strobe cycles of the granted master and
// completes the beat itself when the slave stays silent for TIMEOUT_CYCLES cycles.
module wb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       granted,
  input  logic       stb,
  input  logic       s_ack,
  output logic       wd_ack,
  output logic       timeout_o,
  output logic [7:0] timeout_cnt_o
);
  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt;
  logic        fire_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt           <= '0;
      fire_q        <= 1'b0;
      timeout_cnt_o <= '0;
    end else begin
      // The fire cycle counts as a completion, so the next beat starts from zero.
      if (!granted || !stb || s_ack || fire_q || cnt == LAST)
        cnt <= '0;
      else
        cnt <= cnt + 16'd1;
      fire_q <= granted && stb && !s_ack && !fire_q && (cnt == LAST);
      if (timeout_o && timeout_cnt_o != 8'hFF)
        timeout_cnt_o <= timeout_cnt_o + 8'd1;
    end
  end

  assign wd_ack    = fire_q && granted;
  // A slave ack landing on the fire cycle wins and suppresses the pulse.
  assign timeout_o = wd_ack && !s_ack;
endmodule

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter with whole-cycle bus lock; m0 is the CPU,
// m1 the JTAG debug master. Hung slave beats are completed by wb_watchdog.
module wb_arbiter2
  import wb_arbiter2_pkg::*;
#(
  parameter int                   TIMEOUT_CYCLES = 255,
  parameter logic [WB_DAT_W-1:0] TIMEOUT_DATA   = WB_TIMEOUT_DATA
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [WB_ADR_W-1:0] m0_adr_i,
  input  logic [WB_DAT_W-1:0] m0_dat_i,
  input  logic [WB_SEL_W-1:0] m0_sel_i,
  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  output logic [WB_DAT_W-1:0] m0_dat_o,
  output logic                m0_ack_o,
  input  logic [WB_ADR_W-1:0] m1_adr_i,
  input  logic [WB_DAT_W-1:0] m1_dat_i,
  input  logic [WB_SEL_W-1:0] m1_sel_i,
  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  output logic [WB_DAT_W-1:0] m1_dat_o,
  output logic                m1_ack_o,
  output logic [WB_ADR_W-1:0] s_adr_o,
  output logic [WB_DAT_W-1:0] s_dat_o,
  output logic [WB_SEL_W-1:0] s_sel_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  input  logic [WB_DAT_W-1:0] s_dat_i,
  input  logic                s_ack_i,
  output logic                timeout_o,
  output logic [7:0]          timeout_cnt_o
);
  arb_state_e state, state_nxt;
  logic       last_grant, last_grant_nxt;
  logic       granted, gnt_stb, wd_ack;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Ties go to the master that did not hold the previous tenure.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_grant)) begin
          state_nxt      = GNT0;
          last_grant_nxt = 1'b0;
        end else if (m1_cyc_i) begin
          state_nxt      = GNT1;
          last_grant_nxt = 1'b1;
        end
      end
      GNT0:    if (!m0_cyc_i) state_nxt = IDLE;
      GNT1:    if (!m1_cyc_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign granted = (state == GNT0 && m0_cyc_i) || (state == GNT1 && m1_cyc_i);
  assign gnt_stb = (state == GNT0) ? m0_stb_i : (state == GNT1) ? m1_stb_i : 1'b0;

  wb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .granted       (granted),
    .stb           (gnt_stb),
    .s_ack         (s_ack_i),
    .wd_ack        (wd_ack),
    .timeout_o     (timeout_o),
    .timeout_cnt_o (timeout_cnt_o)
  );

  // Slave-side mux; s_cyc_o follows the owner's cyc so an abort frees the bus at once.
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    case (state)
      GNT0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i && !wd_ack;
        s_we_o   = m0_we_i;
        m0_ack_o = s_ack_i || wd_ack;
        m0_dat_o = timeout_o ? TIMEOUT_DATA : s_dat_i;
      end
      GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i && !wd_ack;
        s_we_o   = m1_we_i;
        m1_ack_o = s_ack_i || wd_ack;
        m1_dat_o = timeout_o ? TIMEOUT_DATA : s_dat_i;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: directed scenarios plus random two-master traffic, with a
// per-master expectation queue drained by an ack monitor.
module tb_wb_arbiter2;
  localparam int          TO      = 8;
  localparam logic [31:0] TO_DATA = 32'hDEADBEEF;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [31:0] m0_adr_i = '0, m0_dat_i = '0, m1_adr_i = '0, m1_dat_i = '0;
  logic [3:0]  m0_sel_i = '0, m1_sel_i = '0;
  logic        m0_cyc_i = 1'b0, m0_stb_i = 1'b0, m0_we_i = 1'b0;
  logic        m1_cyc_i = 1'b0, m1_stb_i = 1'b0, m1_we_i = 1'b0;
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic        m0_ack_o, m1_ack_o;
  logic [3:0]  s_sel_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_dat_i = '0;
  logic        s_ack_i = 1'b0;
  logic        timeout_o;
  logic [7:0]  timeout_cnt_o;

  wb_arbiter2 #(.TIMEOUT_CYCLES(TO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_cyc_i(m0_cyc_i),
    .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_cyc_i(m1_cyc_i),
    .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cyc_o(s_cyc_o),
    .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .timeout_o(timeout_o), .timeout_cnt_o(timeout_cnt_o)
  );

  initial forever #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [31:0] dat;
    logic        rd;
    logic        to;
  } exp_t;

  exp_t        q0[$], q1[$];
  int          n_chk = 0, n_pass = 0, exp_to = 0, cyc_n = 0;
  int          ovr_delay = -1;
  logic [31:0] ovr_data = '0;

  always @(posedge sys_clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
  endtask

  // Slave behaviour: ack after a number of cycles derived from the address (or an override).
  function automatic int sl_delay(input logic [31:0] a);
    return (ovr_delay >= 0) ? ovr_delay : int'(a[3:0]);
  endfunction

  function automatic logic [31:0] sl_data(input logic [31:0] a);
    return (ovr_delay >= 0) ? ovr_data : {a[15:0], ~a[15:0]};
  endfunction

  int          sl_cnt = 0, sl_d = 0;
  bit          sl_busy = 0;
  logic [31:0] sl_dat = '0;

  always @(negedge sys_clk) begin
    s_ack_i = 1'b0;
    s_dat_i = $urandom;
    if (!sys_rst_n || !s_cyc_o) sl_busy = 0;
    else begin
      if (!sl_busy && s_stb_o) begin
        sl_busy = 1; sl_cnt = 0;
        sl_d = sl_delay(s_adr_o); sl_dat = sl_data(s_adr_o);
      end else if (sl_busy && !s_stb_o && sl_cnt != sl_d) sl_busy = 0;
      if (sl_busy) begin
        if (sl_cnt == sl_d) begin
          s_ack_i = 1'b1; s_dat_i = sl_dat; sl_busy = 0;
        end else sl_cnt++;
      end
    end
  end

  // Ack monitor: every ack consumes one expectation of the acked master.
  always @(negedge sys_clk) begin
    exp_t e;
    #2;
    if (sys_rst_n) begin
      if (m0_ack_o && m1_ack_o) check("both_ack", 32'(m1_ack_o), 0);
      else if (m0_ack_o) begin
        if (q0.size() == 0) check("m0_unexpected_ack", 32'(m0_ack_o), 0);
        else begin
          e = q0.pop_front();
          if (e.rd) check("m0_dat", m0_dat_o, e.dat);
          check("m0_timeout_pulse", 32'(timeout_o), 32'(e.to));
          check("m1_dat_idle", m1_dat_o, 0);
        end
      end else if (m1_ack_o) begin
        if (q1.size() == 0) check("m1_unexpected_ack", 32'(m1_ack_o), 0);
        else begin
          e = q1.pop_front();
          if (e.rd) check("m1_dat", m1_dat_o, e.dat);
          check("m1_timeout_pulse", 32'(timeout_o), 32'(e.to));
          check("m0_dat_idle", m0_dat_o, 0);
        end
      end else if (timeout_o) check("timeout_without_ack", 32'(timeout_o), 0);
    end
  end

  task automatic set_m(input int m, input logic cyc, input logic stb, input logic [31:0] a,
                       input logic we, input logic [31:0] d);
    if (m == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_adr_i = a; m0_we_i = we; m0_dat_i = d; m0_sel_i = a[7:4];
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_adr_i = a; m1_we_i = we; m1_dat_i = d; m1_sel_i = a[7:4];
    end
  endtask

  // Issues one beat (cyc+stb), queues its expectation, waits for the ack, leaves cyc held.
  task automatic drive_beat(input int m, input logic [31:0] a, input logic we,
                            input logic [31:0] d, output int ack_cyc);
    exp_t e;
    bit   got = 0;
    int   waited = 0;
    set_m(m, 1'b1, 1'b1, a, we, d);
    e.rd  = !we;
    e.to  = (sl_delay(a) > TO);
    e.dat = e.to ? TO_DATA : sl_data(a);
    if (e.to) exp_to++;
    if (m == 0) q0.push_back(e); else q1.push_back(e);
    while (!got && waited < 2000) begin
      @(negedge sys_clk); #2;
      got = (m == 0) ? m0_ack_o : m1_ack_o;
      waited++;
    end
    ack_cyc = cyc_n;
    if (!got) check("ack_wait_expired", 0, 1);
    @(posedge sys_clk); #1;
    set_m(m, 1'b1, 1'b0, a, we, d);
  endtask

  task automatic next_cycle();
    @(posedge sys_clk); #1;
  endtask

  task automatic rand_master(input int m, input int n);
    int ack_c, nb;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 3)) next_cycle();
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        drive_beat(m, $urandom, 1'($urandom_range(0, 1)), $urandom, ack_c);
        repeat ($urandom_range(0, 2)) next_cycle();
      end
      set_m(m, 1'b0, 1'b0, '0, 1'b0, '0);
      next_cycle();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int a0, a1, st, drop0;
    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_s_cyc", 32'(s_cyc_o), 0);
    check("rst_s_stb", 32'(s_stb_o), 0);
    check("rst_acks", {30'd0, m1_ack_o, m0_ack_o}, 0);
    check("rst_m_dat", m0_dat_o | m1_dat_o, 0);
    check("rst_timeout", 32'(timeout_o), 0);
    check("rst_timeout_cnt", 32'(timeout_cnt_o), 0);
    sys_rst_n = 1'b1;
    next_cycle();

    // Single m1 read, slave acks two cycles after the granted strobe.
    ovr_delay = 2; ovr_data = 32'h12345678;
    st = cyc_n;
    fork
      drive_beat(1, 32'h100, 1'b0, '0, a1);
      begin
        @(negedge sys_clk); #2; check("t1_scyc_arb", 32'(s_cyc_o), 0);
        @(negedge sys_clk); #2; check("t1_scyc_gnt", 32'(s_cyc_o), 1);
        check("t1_sadr", s_adr_o, 32'h100);
      end
    join
    set_m(1, 1'b0, 1'b0, '0, 1'b0, '0);
    check("t1_latency", a1 - st, 3);
    next_cycle();

    // Simultaneous requests: m0 first, then round robin hands the next tie to m1.
    ovr_delay = 0;
    fork
      begin drive_beat(0, 32'h40, 1'b0, '0, a0); set_m(0, 1'b0, 1'b0, '0, 1'b0, '0); end
      begin drive_beat(1, 32'h80, 1'b0, '0, a1); set_m(1, 1'b0, 1'b0, '0, 1'b0, '0); end
    join
    check("t2_m0_first", 32'(a0 < a1), 1);
    check("t2_idle_gap", 32'((a1 - a0) >= 2), 1);
    next_cycle();
    drive_beat(0, 32'h44, 1'b0, '0, a0);
    set_m(0, 1'b0, 1'b0, '0, 1'b0, '0);
    next_cycle();
    fork
      begin drive_beat(0, 32'h48, 1'b0, '0, a0); set_m(0, 1'b0, 1'b0, '0, 1'b0, '0); end
      begin drive_beat(1, 32'h88, 1'b1, 32'h5, a1); set_m(1, 1'b0, 1'b0, '0, 1'b0, '0); end
    join
    check("t2_rr_m1_first", 32'(a1 < a0), 1);
    next_cycle();

    // Silent slave: watchdog completes TO cycles after the strobe is granted.
    ovr_delay = 31;
    st = cyc_n;
    drive_beat(1, 32'h300, 1'b0, '0, a1);
    set_m(1, 1'b0, 1'b0, '0, 1'b0, '0);
    check("t3_latency", a1 - st, TO + 1);
    check("t3_timeout_cnt", 32'(timeout_cnt_o), 1);
    check("t3_pulse_ended", 32'(timeout_o), 0);
    next_cycle();

    // Slave ack on the fire cycle wins.
    ovr_delay = TO; ovr_data = 32'hCAFE0001;
    st = cyc_n;
    drive_beat(1, 32'h304, 1'b0, '0, a1);
    set_m(1, 1'b0, 1'b0, '0, 1'b0, '0);
    check("t4_latency", a1 - st, TO + 1);
    check("t4_timeout_cnt", 32'(timeout_cnt_o), 1);
    next_cycle();

    // Random two-master traffic.
    ovr_delay = -1;
    fork
      rand_master(0, 12);
      rand_master(1, 12);
    join
    next_cycle();
    check("rand_timeout_cnt", 32'(timeout_cnt_o), (exp_to > 255) ? 255 : exp_to);
    check("rand_q_empty", q0.size() + q1.size(), 0);

    // Bus lock over three beats with stb gaps while m1 waits.
    ovr_delay = 1;
    fork
      begin
        for (int b = 0; b < 3; b++) begin
          drive_beat(0, 32'h500 + 32'(b * 4), 1'b0, '0, a0);
          next_cycle();
        end
        set_m(0, 1'b0, 1'b0, '0, 1'b0, '0);
        drop0 = cyc_n;
      end
      begin
        next_cycle();
        drive_beat(1, 32'h600, 1'b0, '0, a1);
        set_m(1, 1'b0, 1'b0, '0, 1'b0, '0);
      end
    join
    check("t5_lock", 32'(a1 > drop0), 1);
    next_cycle();

    // Asynchronous reset in the middle of an m1 beat.
    ovr_delay = 31;
    set_m(1, 1'b1, 1'b1, 32'h700, 1'b0, '0);
    repeat (4) next_cycle();
    check("t5_pre_rst_scyc", 32'(s_cyc_o), 1);
    @(negedge sys_clk); #1;
    sys_rst_n = 1'b0;
    #1;
    check("t5_rst_scyc", 32'(s_cyc_o), 0);
    check("t5_rst_sstb", 32'(s_stb_o), 0);
    check("t5_rst_acks", {30'd0, m1_ack_o, m0_ack_o}, 0);
    check("t5_rst_m1_dat", m1_dat_o, 0);
    set_m(1, 1'b0, 1'b0, '0, 1'b0, '0);
    next_cycle();
    sys_rst_n = 1'b1;
    exp_to = 0;
    check("t5_rst_timeout_cnt", 32'(timeout_cnt_o), 0);
    next_cycle();

    // 300 consecutive timeouts saturate the completion count.
    for (int i = 0; i < 300; i++) drive_beat(0, 32'(i * 16), 1'(i % 2), 32'(i), a0);
    set_m(0, 1'b0, 1'b0, '0, 1'b0, '0);
    next_cycle();
    check("t6_saturate", 32'(timeout_cnt_o), (exp_to > 255) ? 255 : exp_to);
    check("final_q_empty", q0.size() + q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
